// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester accumulator ALU: op codes, FSM states, default width.
package alu_share_pkg;

    localparam int unsigned OPW_DEF = 4;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_ADD5  = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_LOGIC = 3'd3;
    localparam logic [2:0] OP_ORRED = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Single-cycle combinational result for ops 0-6; the multiply is sequenced by the top level.
module alu_exec_unit
    import alu_share_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEF
) (
    input  logic [2:0]       opc_i,
    input  logic [OPW-1:0]   opa_i,
    input  logic [OPW-1:0]   opb_i,
    output logic [2*OPW-1:0] res_o
);

    logic [OPW-1:0] add_y;
    logic [OPW:0]   add_s;
    logic           carry;

    // Full-adder ripple chain shared by increment (B forced to 0, carry-in 1) and 5-bit add.
    always_comb begin
        add_y = (opc_i == OP_INC) ? '0 : opb_i;
        carry = (opc_i == OP_INC);
        add_s = '0;
        for (int unsigned i = 0; i < OPW; i++) begin
            add_s[i] = opa_i[i] ^ add_y[i] ^ carry;
            carry    = (opa_i[i] & add_y[i]) | (carry & (opa_i[i] ^ add_y[i]));
        end
        add_s[OPW] = carry;
    end

    always_comb begin
        res_o = '0;
        case (opc_i)
            OP_INC, OP_ADD5: res_o = {{(OPW-1){1'b0}}, add_s};
            OP_ADD:          res_o = {{OPW{1'b0}}, opa_i} + {{OPW{1'b0}}, opb_i};
            OP_LOGIC:        res_o = {opa_i | opb_i, opa_i ^ opb_i};
            OP_ORRED:        res_o[0] = |{opa_i, opb_i};
            OP_SHL: begin
                if (32'(opa_i) < 2 * OPW) res_o = {{OPW{1'b0}}, opb_i} << opa_i;
            end
            OP_SHR: begin
                if (32'(opa_i) < OPW) res_o = {{OPW{1'b0}}, opb_i >> opa_i};
            end
            default:         res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer owning the shared accumulator; one requester served at a time.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned OPW      = OPW_DEF,
    parameter bit          FIRST_RR = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [OPW-1:0]   a0,
    input  logic [OPW-1:0]   a1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [2*OPW-1:0] acc,
    output logic             busy
);

    localparam int unsigned AW = 2 * OPW;
    localparam int unsigned CW = $clog2(OPW + 1);

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     done_q, done_d;
    logic [2:0]     opc_q, opc_d;
    logic [OPW-1:0] opa_q, opa_d;
    logic [OPW-1:0] opb_q, opb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  prod_q, prod_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [AW-1:0]  exec_res;
    logic           sel;
    logic [2:0]     sel_op;

    alu_exec_unit #(.OPW(OPW)) u_exec (
        .opc_i (opc_q),
        .opa_i (opa_q),
        .opb_i (opb_q),
        .res_o (exec_res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rr_q    <= FIRST_RR;
            gnt_q   <= '0;
            done_q  <= '0;
            opc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            opc_q   <= opc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        opc_d   = opc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        sel     = 1'b0;
        sel_op  = op0;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (req0 || req1) begin
                    // rr_q names the side favoured on contention: the one not granted last.
                    sel    = (req0 && req1) ? rr_q : req1;
                    sel_op = sel ? op1 : op0;
                    rr_d   = ~sel;
                    gnt_d  = sel ? 2'b10 : 2'b01;
                    opc_d  = sel_op;
                    opa_d  = sel ? a1 : a0;
                    opb_d  = acc_q[OPW-1:0];
                    cnt_d  = '0;
                    prod_d = '0;
                    state_d = (sel_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                acc_d   = exec_res;
                state_d = S_DONE;
            end
            S_MUL: begin
                if (cnt_q == CW'(OPW)) begin
                    acc_d   = prod_q;
                    state_d = S_DONE;
                end else begin
                    // Multiplier bits are consumed LSB-first by shifting the latched B.
                    if (opb_q[0]) prod_d = prod_q + (AW'(opa_q) << cnt_q);
                    opb_d = opb_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign done0 = done_q[0];
    assign done1 = done_q[1];
    assign acc   = acc_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios plus randomized requesters vs a schedule model.
module tb_alu_share_ctrl;

    localparam int unsigned OPW = 4;
    localparam bit          FRR = 1'b0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       rq [2];
    logic [2:0] opv [2];
    logic [3:0] av [2];
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [3:0] a0, a1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] acc;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    assign req0 = rq[0];
    assign req1 = rq[1];
    assign op0  = opv[0];
    assign op1  = opv[1];
    assign a0   = av[0];
    assign a1   = av[1];

    alu_share_ctrl #(.OPW(OPW), .FIRST_RR(FRR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .op0     (op0),
        .op1     (op1),
        .a0      (a0),
        .a1      (a1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .acc     (acc),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result straight from the op table, using integer arithmetic.
    function automatic logic [7:0] model_f(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + 1;
            1: r = a + b;
            2: r = a + b;
            3: r = (a | b) * 16 + (a ^ b);
            4: r = (a != 0 || b != 0) ? 1 : 0;
            5: r = (a >= 2 * OPW) ? 0 : (b * (1 << a)) % 256;
            6: r = (a >= OPW) ? 0 : b / (1 << a);
            default: r = a * b;
        endcase
        return 8'(r);
    endfunction

    // Transaction schedule model: a grant at edge S with latency L means gnt over edges S..S+L,
    // acc updated at S+L-1, done at S+L, busy over S..S+L-1, next arbitration at S+L+1.
    int         cyc = 0;
    bit         m_active = 1'b0;
    int         m_start = 0;
    int         m_L = 0;
    int         m_side = 0;
    int         m_fav = int'(FRR);
    logic [7:0] m_acc = '0;
    logic [7:0] m_res = '0;

    always @(posedge clk or negedge reset_n) begin
        int op, a;
        if (!reset_n) begin
            m_active = 1'b0;
            m_acc    = '0;
            m_fav    = int'(FRR);
        end else begin
            cyc++;
            if (m_active && cyc == m_start + m_L - 1) m_acc = m_res;
            if (m_active && cyc == m_start + m_L + 1) m_active = 1'b0;
            if (!m_active && (req0 || req1)) begin
                m_side   = (req0 && req1) ? m_fav : (req1 ? 1 : 0);
                m_fav    = 1 - m_side;
                op       = int'(m_side == 1 ? op1 : op0);
                a        = int'(m_side == 1 ? a1 : a0);
                m_res    = model_f(op, a, int'(m_acc[3:0]));
                m_L      = (op == 7) ? int'(OPW) + 2 : 2;
                m_start  = cyc;
                m_active = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit on, dn, bz;
        if (chk_en) begin
            on = m_active && (cyc <= m_start + m_L);
            dn = m_active && (cyc == m_start + m_L);
            bz = m_active && (cyc < m_start + m_L);
            chk("cyc_gnt0",  32'(gnt0),  32'(on && m_side == 0));
            chk("cyc_gnt1",  32'(gnt1),  32'(on && m_side == 1));
            chk("cyc_done0", 32'(done0), 32'(dn && m_side == 0));
            chk("cyc_done1", 32'(done1), 32'(dn && m_side == 1));
            chk("cyc_busy",  32'(busy),  32'(bz));
            chk("cyc_acc",   32'(acc),   32'(m_acc));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_acc",  32'(acc), 32'h0);
        chk("rst_gnt",  32'({gnt1, gnt0}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic run_op(input int side, input logic [2:0] op, input logic [3:0] a,
                          input int exp_lat, input logic [7:0] exp_acc, input string nm);
        int n;
        bit seen, other;
        logic [7:0] pre;
        @(negedge clk);
        rq[side]  = 1'b1;
        opv[side] = op;
        av[side]  = a;
        n = cyc + 1;
        pre = m_acc;
        seen = 1'b0;
        other = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if ((side == 0 ? gnt1 : gnt0) === 1'b1) other = 1'b1;
            if ((side == 0 ? done0 : done1) === 1'b1) seen = 1'b1;
            else if (cyc <= n + exp_lat - 2) chk({nm, "_hold"}, 32'(acc), 32'(pre));
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'h0, 32'h1);
        end else begin
            chk({nm, "_lat"}, 32'(cyc - n), 32'(exp_lat));
            chk({nm, "_acc"}, 32'(acc), 32'(exp_acc));
            chk({nm, "_model"}, 32'(m_acc), 32'(exp_acc));
            chk({nm, "_othergnt"}, 32'(other), 32'h0);
        end
        rq[side] = 1'b0;
    endtask

    task automatic agent(input int s);
        logic g, d;
        g = (s == 1) ? gnt1 : gnt0;
        d = (s == 1) ? done1 : done0;
        if (d) begin
            if ($urandom_range(0, 1) == 0) rq[s] = 1'b0;
            else begin
                opv[s] = 3'($urandom_range(0, 7));
                av[s]  = 4'($urandom_range(0, 15));
            end
        end else if (!rq[s]) begin
            opv[s] = 3'($urandom_range(0, 7));
            av[s]  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq[s] = 1'b1;
        end else if (g) begin
            if ($urandom_range(0, 7) == 0) begin
                opv[s] = 3'($urandom_range(0, 7));
                av[s]  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) rq[s] = 1'b0;
        end
    endtask

    int exp_side [4] = '{0, 1, 0, 1};
    int exp_accs [4] = '{1, 3, 4, 6};

    initial begin
        int cnt, last, n, dcount;
        rq[0] = 1'b0; rq[1] = 1'b0;
        opv[0] = '0; opv[1] = '0;
        av[0] = '0; av[1] = '0;

        do_reset();
        run_op(0, 3'd0, 4'd5, 2, 8'h06, "inc5");
        run_op(1, 3'd7, 4'hF, 6, 8'h5A, "mul15x6");

        do_reset();
        @(negedge clk);
        rq[0] = 1'b1; opv[0] = 3'd2; av[0] = 4'd1;
        rq[1] = 1'b1; opv[1] = 3'd2; av[1] = 4'd2;
        cnt = 0;
        last = 0;
        for (int k = 0; k < 40 && cnt < 4; k++) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1) begin
                chk("rr_side", 32'(done1), 32'(exp_side[cnt]));
                chk("rr_acc", 32'(acc), 32'(exp_accs[cnt]));
                if (cnt > 0) chk("rr_interval", 32'(cyc - last), 32'd3);
                last = cyc;
                cnt++;
                if (cnt == 4) begin
                    rq[0] = 1'b0;
                    rq[1] = 1'b0;
                end
            end
        end
        chk("rr_count", 32'(cnt), 32'd4);
        rq[0] = 1'b0;
        rq[1] = 1'b0;

        do_reset();
        run_op(0, 3'd2, 4'hF, 2, 8'h0F, "set0f");
        run_op(0, 3'd5, 4'd4, 2, 8'hF0, "shl4");
        run_op(1, 3'd5, 4'd9, 2, 8'h00, "shl9");
        run_op(0, 3'd2, 4'hF, 2, 8'h0F, "set0f_b");
        run_op(1, 3'd6, 4'd5, 2, 8'h00, "shr5");
        run_op(0, 3'd3, 4'd5, 2, 8'h55, "logic");
        run_op(1, 3'd4, 4'd0, 2, 8'h01, "orred");
        run_op(0, 3'd0, 4'hF, 2, 8'h10, "inc_carry");
        run_op(1, 3'd1, 4'hF, 2, 8'h0F, "add5_b0");
        run_op(0, 3'd1, 4'hF, 2, 8'h1E, "add5_carry");
        run_op(1, 3'd2, 4'hF, 2, 8'h1D, "add_e");
        run_op(0, 3'd6, 4'd2, 2, 8'h03, "shr2");

        do_reset();
        run_op(0, 3'd2, 4'd3, 2, 8'h03, "set03");
        @(negedge clk);
        rq[0] = 1'b1; opv[0] = 3'd7; av[0] = 4'd5;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        rq[0] = 1'b0;
        @(negedge clk);
        chk("abort_acc", 32'(acc), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_gnt", 32'({gnt1, gnt0}), 32'h0);
        #2 reset_n = 1'b1;
        dcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1) dcount++;
        end
        chk("abort_nodone", 32'(dcount), 32'h0);
        run_op(0, 3'd2, 4'd7, 2, 8'h07, "post_abort");

        @(negedge clk);
        rq[0] = 1'b1; opv[0] = 3'd2; av[0] = 4'd4;
        n = cyc + 1;
        @(negedge clk);
        rq[0] = 1'b0; opv[0] = 3'd7; av[0] = 4'd0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                dcount++;
                chk("drop_lat", 32'(cyc - n), 32'd2);
            end
        end
        chk("drop_done_once", 32'(dcount), 32'd1);
        chk("drop_latched_acc", 32'(acc), 32'h0B);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 700) == 0) begin
                #2 reset_n = 1'b0;
                rq[0] = 1'b0;
                rq[1] = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end else begin
                agent(0);
                agent(1);
            end
        end
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
